// File: rtl/ntt_ctrl_if.sv
// Command, RAM/ROM address and butterfly-mode bus of the NTT sequencing controller.
// master = command/datapath side, slave = ntt_ctrl.
interface ntt_ctrl_if;
  logic       start;
  logic       inv;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [7:0] tw_addr;
  logic [1:0] bf_mode;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  modport master (
    output start, inv,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode,
    input  wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, inv,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode,
    output wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_ctrl.sv
// In-place 256-point forward/inverse NTT sequencer for the Dilithium butterfly datapath.
// Optional INTT n^-1 scaling pass enabled by defining NTT_CTRL_INTT_SCALE_EN.
module ntt_ctrl #(
  parameter int unsigned RAM_LAT   = 1,
  parameter int unsigned BF_LAT    = 3,
  parameter logic [7:0]  SCALE_IDX = 8'd0
) (
  input logic       clk,
  input logic       rst_n,
  ntt_ctrl_if.slave bus
);
  localparam int unsigned L  = RAM_LAT + BF_LAT;
  localparam int unsigned CW = $clog2(L + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
    logic [1:0] mode;
  } issue_t;

  // Butterfly addressing for stage s of a forward (CT) or inverse (GS) pass.
  function automatic issue_t bf_calc(input logic [2:0] s, input logic [6:0] i, input logic iv);
    logic [7:0] len, grp, j;
    bf_calc = '0;
    if (!iv) begin
      len          = 8'd128 >> s;
      grp          = {1'b0, i} >> (3'd7 - s);
      j            = (grp << (4'd8 - {1'b0, s})) | ({1'b0, i} & (len - 8'd1));
      bf_calc.tw   = (8'd1 << s) + grp;
      bf_calc.mode = 2'b00;
    end else begin
      len          = 8'd1 << s;
      grp          = {1'b0, i} >> s;
      j            = (grp << ({1'b0, s} + 4'd1)) | ({1'b0, i} & (len - 8'd1));
      bf_calc.tw   = (8'd255 >> s) - grp;
      bf_calc.mode = 2'b01;
    end
    bf_calc.a = j;
    bf_calc.b = j + len;
  endfunction

  function automatic issue_t next_issue(input logic [3:0] s, input logic [6:0] i, input logic iv);
`ifdef NTT_CTRL_INTT_SCALE_EN
    if (s[3]) begin
      next_issue.a    = {i, 1'b0};
      next_issue.b    = {i, 1'b1};
      next_issue.tw   = SCALE_IDX;
      next_issue.mode = 2'b10;
    end else begin
      next_issue = bf_calc(s[2:0], i, iv);
    end
`else
    next_issue = bf_calc(s[2:0], i, iv);
`endif
  endfunction

  state_t          state;
  logic            inv_q;
  logic [3:0]      stage;
  logic [6:0]      idx;
  logic [CW-1:0]   cnt;
  logic            busy_q, done_q;
  logic [3:0]      last_stage;

  logic            fire;
  logic [3:0]      iss_s;
  logic [6:0]      iss_i;
  logic            iss_inv;
  issue_t          iss;

  logic            rd_en_q;
  logic [7:0]      rd_a, rd_b, tw_q;
  logic [1:0]      rd_mode;

  logic [L-1:0]    wv;
  logic [7:0]      wa [L];
  logic [7:0]      wb [L];
  logic [1:0]      mp [RAM_LAT];

`ifdef NTT_CTRL_INTT_SCALE_EN
  assign last_stage = inv_q ? 4'd8 : 4'd7;
`else
  assign last_stage = 4'd7;
`endif

  // Issue decision looks one cycle ahead so the read strobe/addresses are registered.
  always_comb begin
    iss_s   = stage;
    iss_i   = idx + 7'd1;
    iss_inv = inv_q;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        iss_s   = '0;
        iss_i   = '0;
        iss_inv = bus.inv;
        fire    = bus.start;
      end
      ISSUE: fire = (idx != 7'd127);
      DRAIN: begin
        iss_s = stage + 4'd1;
        iss_i = '0;
        fire  = (cnt == CW'(L - 1)) && (stage != last_stage);
      end
      default: fire = 1'b0;
    endcase
  end

  assign iss = next_issue(iss_s, iss_i, iss_inv);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= IDLE;
      inv_q  <= 1'b0;
      stage  <= '0;
      idx    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          inv_q  <= bus.inv;
          stage  <= '0;
          idx    <= '0;
          busy_q <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: if (idx == 7'd127) begin
          cnt   <= '0;
          state <= DRAIN;
        end else begin
          idx <= idx + 7'd1;
        end
        DRAIN: if (cnt == CW'(L - 1)) begin
          if (stage == last_stage) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            stage <= stage + 4'd1;
            idx   <= '0;
            state <= ISSUE;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_en_q <= 1'b0;
      rd_a    <= '0;
      rd_b    <= '0;
      tw_q    <= '0;
      rd_mode <= '1;
    end else begin
      rd_en_q <= fire;
      if (fire) begin
        rd_a    <= iss.a;
        rd_b    <= iss.b;
        tw_q    <= iss.tw;
        rd_mode <= iss.mode;
      end
    end
  end

  // Write-back and mode delay lines; idle slots carry mode 11.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wv <= '0;
      for (int unsigned k = 0; k < L; k++) begin
        wa[k] <= '0;
        wb[k] <= '0;
      end
      for (int unsigned k = 0; k < RAM_LAT; k++) mp[k] <= '1;
    end else begin
      wv[0] <= rd_en_q;
      wa[0] <= rd_a;
      wb[0] <= rd_b;
      for (int unsigned k = 1; k < L; k++) begin
        wv[k] <= wv[k-1];
        wa[k] <= wa[k-1];
        wb[k] <= wb[k-1];
      end
      mp[0] <= rd_en_q ? rd_mode : 2'b11;
      for (int unsigned k = 1; k < RAM_LAT; k++) mp[k] <= mp[k-1];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a;
  assign bus.rd_addr_b = rd_b;
  assign bus.tw_addr   = tw_q;
  assign bus.bf_mode   = mp[RAM_LAT-1];
  assign bus.wr_en     = wv[L-1];
  assign bus.wr_addr_a = wa[L-1];
  assign bus.wr_addr_b = wb[L-1];
endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: per-cycle schedule model, busy-start, mid-run reset.
module tb_ntt_ctrl;
  localparam int RL = 1;
  localparam int BL = 3;
  localparam int L  = RL + BL;
  localparam int P  = 128 + L;
  localparam logic [7:0] SCALE = 8'd0;
`ifdef NTT_CTRL_INTT_SCALE_EN
  localparam int NST_INV = 9;
`else
  localparam int NST_INV = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cur_cyc = 0;

  ntt_ctrl_if bus ();

  ntt_ctrl #(.RAM_LAT(RL), .BF_LAT(BL), .SCALE_IDX(SCALE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cur_cyc, obs, exp_v);
    end
  endtask

  // Reference schedule: what the read port should carry in cycle c of an operation.
  task automatic model(input int c, input bit iv, input int nst, output bit en,
                       output logic [7:0] a, output logic [7:0] b, output logic [7:0] tw,
                       output logic [1:0] md);
    int k, s, i, len, g, j;
    en = 1'b0; a = '0; b = '0; tw = '0; md = 2'b11;
    if (c < 1) return;
    k = c - 1;
    s = k / P;
    i = k % P;
    if (s >= nst || i >= 128) return;
    en = 1'b1;
    if (s == 8) begin
      a = 8'(2 * i); b = 8'(2 * i + 1); tw = SCALE; md = 2'b10;
    end else begin
      len = iv ? (2 ** s) : (128 / (2 ** s));
      g   = i / len;
      j   = g * 2 * len + i % len;
      a   = 8'(j);
      b   = 8'(j + len);
      tw  = iv ? 8'(2 ** (8 - s) - 1 - g) : 8'(2 ** s + g);
      md  = iv ? 2'b01 : 2'b00;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".done"}, 32'(bus.done), 0);
    chk({tag, ".rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, ".rd_a"}, 32'(bus.rd_addr_a), 0);
    chk({tag, ".rd_b"}, 32'(bus.rd_addr_b), 0);
    chk({tag, ".tw"}, 32'(bus.tw_addr), 0);
    chk({tag, ".bf_mode"}, 32'(bus.bf_mode), 3);
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, ".wr_a"}, 32'(bus.wr_addr_a), 0);
    chk({tag, ".wr_b"}, 32'(bus.wr_addr_b), 0);
  endtask

  task automatic run_op(input bit iv, input bit poke, input int rst_at);
    int nst, dcyc;
    bit en, wen, men;
    logic [7:0] a, b, tw, wa, wb, t0, t1, t2;
    logic [1:0] md, d0, mexp;
    nst  = iv ? NST_INV : 8;
    dcyc = nst * P + 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.inv   = iv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.inv   = ~iv;
    for (int c = 1; c <= dcyc + 2; c++) begin
      @(negedge clk);
      cur_cyc = c;
      model(c, iv, nst, en, a, b, tw, md);
      model(c - L, iv, nst, wen, wa, wb, t0, d0);
      model(c - RL, iv, nst, men, t1, t2, t0, mexp);
      chk("rd_en", 32'(bus.rd_en), 32'(en));
      if (en) begin
        chk("rd_addr_a", 32'(bus.rd_addr_a), 32'(a));
        chk("rd_addr_b", 32'(bus.rd_addr_b), 32'(b));
        chk("tw_addr", 32'(bus.tw_addr), 32'(tw));
      end
      chk("wr_en", 32'(bus.wr_en), 32'(wen));
      if (wen) begin
        chk("wr_addr_a", 32'(bus.wr_addr_a), 32'(wa));
        chk("wr_addr_b", 32'(bus.wr_addr_b), 32'(wb));
      end
      chk("bf_mode", 32'(bus.bf_mode), 32'(mexp));
      chk("done", 32'(bus.done), 32'(c == dcyc));
      chk("busy", 32'(bus.busy), 32'(c <= dcyc));
      // hand-computed anchor points
      if (!iv && c == 1) begin
        chk("ntt_first_b", 32'(bus.rd_addr_b), 128);
        chk("ntt_first_tw", 32'(bus.tw_addr), 1);
      end
      if (!iv && c == 2) chk("ntt_first_mode", 32'(bus.bf_mode), 0);
      if (!iv && c == 1 + P + 64) begin
        chk("ntt_s1_i64_a", 32'(bus.rd_addr_a), 128);
        chk("ntt_s1_i64_b", 32'(bus.rd_addr_b), 192);
        chk("ntt_s1_i64_tw", 32'(bus.tw_addr), 3);
      end
      if (!iv && c == 1057) chk("ntt_done_1057", 32'(bus.done), 1);
      if (iv && c == 1) begin
        chk("intt_first_b", 32'(bus.rd_addr_b), 1);
        chk("intt_first_tw", 32'(bus.tw_addr), 255);
      end
      if (iv && c > 7 * P && c <= 7 * P + 128) chk("intt_s7_tw", 32'(bus.tw_addr), 1);
      if (c == P) chk("hazard_last_wr", 32'(bus.wr_en), 1);
      if (c == P + 1) chk("hazard_next_rd", 32'(bus.rd_en), 1);
      if (poke && c == 300) begin
        bus.start = 1'b1;
        bus.inv   = ~iv;
      end else begin
        bus.start = 1'b0;
      end
      if (rst_at != 0 && c == rst_at) begin
        #1 rst_n = 1'b1;
        #1 reset_checks("async_rst");
        repeat (2) @(negedge clk);
        reset_checks("rst_held");
        rst_n = 1'b0;
        for (int q = 0; q < 20; q++) begin
          @(negedge clk);
          chk("post_rst_wr_en", 32'(bus.wr_en), 0);
          chk("post_rst_rd_en", 32'(bus.rd_en), 0);
          chk("post_rst_busy", 32'(bus.busy), 0);
          chk("post_rst_bf_mode", 32'(bus.bf_mode), 3);
        end
        return;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.inv   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("idle");

    run_op(1'b0, 1'b1, 0);    // NTT with ignored start at cycle 300
    run_op(1'b1, 1'b0, 0);    // INTT
    run_op(1'b0, 1'b0, 500);  // NTT aborted by reset at cycle 500
    run_op(1'b0, 1'b0, 0);    // fresh NTT after reset
    run_op(1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencing controller for the Dilithium butterfly datapath: runs a full 256-point forward NTT or inverse NTT in place over a dual-port coefficient RAM. It drives the RAM read/write ports, the twiddle ROM address and the butterfly mode, and delays write-back addresses to match the datapath pipeline. It sits between the top-level command interface and the pipelined butterfly unit.

## Interface
- `RAM_LAT`, default 1: coefficient RAM and twiddle ROM read latency in cycles.
- `BF_LAT`, default 3: butterfly unit latency, from operand capture to `c`/`d` valid.
- `SCALE_IDX`, default 0: twiddle ROM index of n^-1 (used only by the scaling pass).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `inv` in 1: operation select, sampled with `start`; 0 = NTT, 1 = INTT.
- `busy` out 1: high from the cycle after `start` is accepted through the `done` cycle.
- `done` out 1: one-cycle pulse when the transform is complete.
- `rd_en` out 1: RAM read strobe for both ports.
- `rd_addr_a`, `rd_addr_b` out 8 each: read addresses for the upper and lower butterfly operands.
- `tw_addr` out 8: twiddle ROM index, issued with `rd_en`.
- `bf_mode` out 2: butterfly mode; 00 NTT, 01 INTT, 10 bypass/scale, 11 idle.
- `wr_en` out 1: RAM write strobe for both ports.
- `wr_addr_a`, `wr_addr_b` out 8 each: write addresses for `c` and `d`.

## Operation
- States:
  - IDLE: `start` latches `inv`, sets s=0, i=0 and goes to ISSUE.
  - ISSUE: one butterfly per cycle, i = 0..127. After i=127 goes to DRAIN.
  - DRAIN: exactly L = RAM_LAT+BF_LAT cycles. Then goes to ISSUE with s+1, or to DONE after s=7.
  - DONE: one cycle, then IDLE.
- Forward NTT, stage s:
  - len = 128>>s, j = (i/len)·2·len + i%len.
  - addr_a = j, addr_b = j+len.
  - tw_addr = 2^s + i/len, giving 1..255.
- Inverse NTT, stage s:
  - len = 1<<s, same j/addr formula.
  - tw_addr = 2^(8−s) − 1 − i/len, giving 255 down to 1. Twiddle negation is done by the datapath in mode 01.
- Arithmetic: all address math is 8-bit unsigned; divisions and moduli are shifts and masks of i; there is no wrap (j+len ≤ 255).
- Write-back: `wr_en`, `wr_addr_a` and `wr_addr_b` are `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by exactly L cycles through a shift pipeline.
- `bf_mode`: 00 or 01 (per latched `inv`), or 10 for the scaling pass, delayed RAM_LAT cycles from the matching `rd_en`. It is 11 in all other cycles.
- `start` while `busy` is ignored; the latched `inv` is unchanged.
- Reset at any time, including mid-transform:
  - state returns to IDLE and the delay pipeline is cleared.
  - every output is 0, except `bf_mode` = 11.
  - no write is issued after reset; the RAM contents are undefined and a new `start` is required.

## Timing
- `start` is accepted at edge 0; the first `rd_en` is in cycle 1.
- Each stage is 128 issue cycles plus L drain cycles.
- The last write of stage s lands in the final DRAIN cycle. The first read of stage s+1 follows in the next cycle, so there is no RAW hazard.
- `done` asserts in cycle 8·(128+L)+1, which is 1057 with defaults. `busy` falls the following cycle.
- `rd_en` runs in bursts of 128 consecutive cycles per stage; `wr_en` repeats the same pattern L cycles later.

## Configuration
- Macro: `NTT_CTRL_INTT_SCALE_EN`.
- Defined: an INTT runs a ninth pass (stage 8) after stage 7's drain.
  - Pairs (2i, 2i+1), i = 0..127.
  - `bf_mode` = 10, `tw_addr` = SCALE_IDX.
  - The pass ends with a full L-cycle drain; then DONE.
  - INTT `done` arrives at cycle 9·(128+L)+1 = 1189. NTT is unchanged.
- Undefined: no scaling pass; the scaling logic and the `bf_mode` 10 encoding are never generated.

## Test plan
- Reset, then `start` with `inv`=0:
  - first issue is addr_a=0, addr_b=128, tw=1, bf_mode=00 one cycle later.
  - stage 1, i=64 issues addr 128/192, tw=3.
  - `done` at cycle 1057.
  - the full bench output matches a golden Dilithium NTT.
- `start` with `inv`=1:
  - stage 0, i=0 issues addr 0/1, tw=255; stage 7 issues tw=1 for all i.
  - the result matches the reference INTT (with the macro, the scaled INTT; `done` at 1189).
- Write alignment: every `wr_en`/`wr_addr` equals the `rd_en`/`rd_addr` from exactly 4 cycles earlier, with no gaps inside a stage.
- Hazard check: the last `wr_en` of each stage occurs exactly one cycle before the next stage's first `rd_en`.
- `start` pulsed at cycle 300 while `busy`: ignored, and `done` still occurs at cycle 1057.
- Assert `rst_n` at cycle 500:
  - all outputs are 0 with `bf_mode`=11 immediately (asynchronously).
  - no `wr_en` appears after reset.
  - a new `start` completes normally.
